// File: rtl/cpu_frame_sched.sv
// ==========================================================================
// cpu_frame_sched: per-frame sequencer for the CPU (boot hold, WAIT/vsync
// hand-off, GPU start, key-bitmap copy into data memory). Rev 1.0
// ==========================================================================
`default_nettype none

module cpu_frame_sched #(
  parameter int DATA_ADDR_WIDTH = 13,
  parameter int KEY_MEM         = 8176,
  parameter int KEY_WORDS       = 16,
  parameter int RESET_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic [KEY_WORDS-1:0]       keys,
  input  logic                       cpu_wait,
  output logic                       cpu_reset,
  output logic                       cpu_resume,
  input  logic                       cpu_we,
  input  logic [DATA_ADDR_WIDTH-1:0] cpu_waddr,
  input  logic [15:0]                cpu_wdata,
  output logic                       mem_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_waddr,
  output logic [15:0]                mem_wdata,
  output logic                       gpu_start,
  input  logic                       gpu_busy,
  output logic [15:0]                frame_count,
  output logic [15:0]                overrun_count
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int IDX_W  = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  localparam logic [HOLD_W-1:0]          HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0]           IDX_LAST  = IDX_W'(KEY_WORDS - 1);
  localparam logic [DATA_ADDR_WIDTH-1:0] KEY_BASE  = DATA_ADDR_WIDTH'(KEY_MEM);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_RUN     = 3'd1,
    S_DONE    = 3'd2,
    S_KEYCOPY = 3'd3,
    S_RESUME  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [KEY_WORDS-1:0] key_q, key_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [15:0]          overrun_q, overrun_d;

  logic frame_slot;
  logic start_frame;
  logic overrun_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      hold_q        <= '0;
      idx_q         <= '0;
      key_q         <= '0;
      frame_count_q <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      key_q         <= key_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  // A vsync arriving together with WAIT is handled exactly like one in DONE.
  assign frame_slot = (state_q == S_DONE) || ((state_q == S_RUN) && cpu_wait);

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    idx_d         = idx_q;
    key_d         = key_q;
    frame_count_d = frame_count_q;
    start_frame   = 1'b0;
    overrun_inc   = 1'b0;

    case (state_q)
      S_BOOT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_wait) begin
          state_d = S_DONE;
        end else if (vsync) begin
          overrun_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_KEYCOPY: begin
        overrun_inc = vsync;
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = S_RESUME;
        end
      end
      S_RESUME: begin
        overrun_inc   = vsync;
        frame_count_d = frame_count_q + 16'd1;
        state_d       = S_RUN;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    if (frame_slot && vsync) begin
      if (gpu_busy) begin
        overrun_inc = 1'b1;
      end else begin
        start_frame = 1'b1;
        key_d       = keys;
        idx_d       = '0;
        state_d     = S_KEYCOPY;
      end
    end

    overrun_d = overrun_q;
    if (overrun_inc && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  // Data-memory write port: CPU owns it while running, the key copier in KEYCOPY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      S_RUN, S_DONE: begin
        mem_we    = cpu_we;
        mem_waddr = cpu_waddr;
        mem_wdata = cpu_wdata;
      end
      S_KEYCOPY: begin
        mem_we    = 1'b1;
        mem_waddr = KEY_BASE + DATA_ADDR_WIDTH'(idx_q);
        mem_wdata = {15'b0, key_q[idx_q]};
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign cpu_reset     = reset || (state_q == S_BOOT);
  assign cpu_resume    = (state_q == S_RESUME);
  assign gpu_start     = start_frame;
  assign frame_count   = frame_count_q;
  assign overrun_count = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_frame_sched.sv
// Bench for cpu_frame_sched: directed frame scenarios plus randomized traffic
// checked against a phase-counting reference model.
`default_nettype none

module tb_cpu_frame_sched;

  localparam int AW = 13;
  localparam int KEY_MEM = 8176;
  localparam int KW = 16;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic [KW-1:0] keys = '0;
  logic          cpu_wait = 1'b0;
  logic          cpu_reset, cpu_resume;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_waddr = '0;
  logic [15:0]   cpu_wdata = '0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic          gpu_start;
  logic          gpu_busy = 1'b0;
  logic [15:0]   frame_count, overrun_count;

  int n_checks = 0;
  int n_fail = 0;

  cpu_frame_sched #(
    .DATA_ADDR_WIDTH(AW), .KEY_MEM(KEY_MEM), .KEY_WORDS(KW), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .keys(keys), .cpu_wait(cpu_wait),
    .cpu_reset(cpu_reset), .cpu_resume(cpu_resume), .cpu_we(cpu_we),
    .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .gpu_start(gpu_start),
    .gpu_busy(gpu_busy), .frame_count(frame_count), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is described by how many boot cycles remain,
  // whether the CPU is parked waiting for vsync, which key word is next, and
  // whether a resume is owed.
  int          m_boot_left = RC;
  bit          m_halted = 1'b0;
  int          m_copy = -1;
  bit          m_resume = 1'b0;
  logic [15:0] m_keys = '0;
  int          m_frames = 0;
  int          m_overruns = 0;

  logic          e_cpu_reset, e_cpu_resume, e_mem_we, e_gpu_start;
  logic [AW-1:0] e_mem_waddr;
  logic [15:0]   e_mem_wdata;

  task automatic note_overrun();
    if (m_overruns < 65535) m_overruns++;
  endtask

  task automatic model_advance();
    if (reset) begin
      m_boot_left = RC; m_halted = 1'b0; m_copy = -1; m_resume = 1'b0;
      m_frames = 0; m_overruns = 0;
    end else if (m_boot_left > 0) begin
      m_boot_left--;
    end else if (m_copy >= 0) begin
      if (vsync) note_overrun();
      m_copy++;
      if (m_copy == KW) begin
        m_copy = -1;
        m_resume = 1'b1;
      end
    end else if (m_resume) begin
      if (vsync) note_overrun();
      m_resume = 1'b0;
      m_frames = (m_frames + 1) % 65536;
    end else if (m_halted || cpu_wait) begin
      if (!vsync) begin
        m_halted = 1'b1;
      end else if (gpu_busy) begin
        note_overrun();
        m_halted = 1'b1;
      end else begin
        m_keys = keys;
        m_copy = 0;
        m_halted = 1'b0;
      end
    end else if (vsync) begin
      note_overrun();
    end
  endtask

  task automatic model_outputs();
    bit cpu_owns;
    cpu_owns = (m_boot_left == 0) && (m_copy < 0) && !m_resume;
    e_cpu_reset  = reset || (m_boot_left > 0);
    e_cpu_resume = m_resume;
    e_gpu_start  = cpu_owns && vsync && !gpu_busy && (m_halted || cpu_wait);
    if (m_copy >= 0) begin
      e_mem_we    = 1'b1;
      e_mem_waddr = AW'(KEY_MEM + m_copy);
      e_mem_wdata = {15'b0, m_keys[m_copy]};
    end else if (cpu_owns) begin
      e_mem_we    = cpu_we;
      e_mem_waddr = cpu_waddr;
      e_mem_wdata = cpu_wdata;
    end else begin
      e_mem_we    = 1'b0;
      e_mem_waddr = '0;
      e_mem_wdata = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (cpu_reset !== 1'b1 || frame_count !== 16'd0 || overrun_count !== 16'd0 ||
        mem_we !== 1'b0 || cpu_resume !== 1'b0 || gpu_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got rst=%b fc=%0d oc=%0d we=%b res=%b gs=%b exp 1 0 0 0 0 0",
               cpu_reset, frame_count, overrun_count, mem_we, cpu_resume, gpu_start);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < RC + 2; i++) begin
      cpu_we = (i >= RC); cpu_waddr = AW'(100 + i); cpu_wdata = 16'(16'hA000 + i);
      @(negedge clk);
      n_checks++;
      if (cpu_reset !== (i < RC)) begin
        n_fail++;
        $display("FAIL boot_hold cycle=%0d got=%b exp=%b", i, cpu_reset, (i < RC));
      end
      n_checks++;
      if (mem_we !== (i >= RC) || (i >= RC && (mem_waddr !== AW'(100 + i) || mem_wdata !== 16'(16'hA000 + i)))) begin
        n_fail++;
        $display("FAIL run_mux cycle=%0d got we=%b a=%0d d=%h exp we=%b", i, mem_we, mem_waddr, mem_wdata, (i >= RC));
      end
      tick();
    end
    cpu_we = 1'b0;
  endtask

  task automatic check_copy(input logic [15:0] kv, input string tag);
    for (int i = 0; i < KW; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1 || mem_waddr !== AW'(KEY_MEM + i) || mem_wdata !== {15'b0, kv[i]}) begin
        n_fail++;
        $display("FAIL %s_copy idx=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                 tag, i, mem_we, mem_waddr, mem_wdata, KEY_MEM + i, {15'b0, kv[i]});
      end
      keys = 16'($urandom);
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (cpu_resume !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_resume got res=%b we=%b exp res=1 we=0", tag, cpu_resume, mem_we);
    end
    tick();
    cpu_wait = 1'b0;
  endtask

  task automatic test_frame();
    cpu_wait = 1'b1;
    tick();
    vsync = 1'b1; gpu_busy = 1'b0; keys = 16'h0005;
    @(negedge clk);
    n_checks++;
    if (gpu_start !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_gpu_start got=%b exp=1", gpu_start);
    end
    tick();
    vsync = 1'b0;
    check_copy(16'h0005, "frame");
    @(negedge clk);
    n_checks++;
    if (cpu_resume !== 1'b0 || frame_count !== 16'd1) begin
      n_fail++;
      $display("FAIL frame_count got res=%b fc=%0d exp res=0 fc=1", cpu_resume, frame_count);
    end
    tick();
  endtask

  task automatic test_overrun_run();
    vsync = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gpu_start !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL run_vsync got gs=%b we=%b exp gs=0 we=0", gpu_start, mem_we);
    end
    tick();
    vsync = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun_count !== 16'd1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL run_overrun got oc=%0d we=%b exp oc=1 we=0", overrun_count, mem_we);
    end
    tick();
  endtask

  task automatic test_wait_and_vsync();
    logic [15:0] kv;
    kv = 16'($urandom);
    cpu_wait = 1'b1; vsync = 1'b1; gpu_busy = 1'b0; keys = kv;
    @(negedge clk);
    n_checks++;
    if (gpu_start !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_gpu_start got=%b exp=1", gpu_start);
    end
    tick();
    vsync = 1'b0;
    check_copy(kv, "same_cycle");
    @(negedge clk);
    n_checks++;
    if (overrun_count !== 16'd1 || frame_count !== 16'd2) begin
      n_fail++;
      $display("FAIL same_cycle_counts got oc=%0d fc=%0d exp oc=1 fc=2", overrun_count, frame_count);
    end
    tick();
  endtask

  task automatic test_busy();
    logic [15:0] kv;
    kv = 16'($urandom);
    cpu_wait = 1'b1;
    tick();
    vsync = 1'b1; gpu_busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gpu_start !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_gpu_start got=%b exp=0", gpu_start);
    end
    tick();
    vsync = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overrun_count !== 16'd2 || mem_we !== 1'b0 || cpu_resume !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_overrun got oc=%0d we=%b res=%b exp oc=2 we=0 res=0", overrun_count, mem_we, cpu_resume);
    end
    tick();
    tick();
    vsync = 1'b1; gpu_busy = 1'b0; keys = kv;
    @(negedge clk);
    n_checks++;
    if (gpu_start !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_retry_start got=%b exp=1", gpu_start);
    end
    tick();
    vsync = 1'b0;
    check_copy(kv, "busy");
    @(negedge clk);
    n_checks++;
    if (frame_count !== 16'd3 || overrun_count !== 16'd2) begin
      n_fail++;
      $display("FAIL busy_counts got fc=%0d oc=%0d exp fc=3 oc=2", frame_count, overrun_count);
    end
    tick();
  endtask

  task automatic test_reset_midcopy();
    cpu_wait = 1'b1; vsync = 1'b1; gpu_busy = 1'b0; keys = 16'hFFFF;
    tick();
    vsync = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_reset !== 1'b1 || mem_waddr !== AW'(KEY_MEM + 7)) begin
      n_fail++;
      $display("FAIL midcopy_reset_comb got rst=%b a=%0d exp rst=1 a=%0d", cpu_reset, mem_waddr, KEY_MEM + 7);
    end
    tick();
    reset = 1'b0; cpu_wait = 1'b0;
    for (int i = 0; i < RC + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_reset !== (i < RC) || mem_we !== 1'b0 || frame_count !== 16'd0 || overrun_count !== 16'd0) begin
        n_fail++;
        $display("FAIL midcopy_reboot cycle=%0d got rst=%b we=%b fc=%0d oc=%0d exp rst=%b we=0 fc=0 oc=0",
                 i, cpu_reset, mem_we, frame_count, overrun_count, (i < RC));
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      vsync     = ($urandom_range(0, 5) == 0);
      cpu_wait  = ($urandom_range(0, 3) == 0);
      gpu_busy  = ($urandom_range(0, 2) == 0);
      keys      = 16'($urandom);
      cpu_we    = 1'($urandom);
      cpu_waddr = AW'($urandom);
      cpu_wdata = 16'($urandom);
      @(negedge clk);
      model_outputs();
      n_checks++;
      if (cpu_reset !== e_cpu_reset) begin
        n_fail++; $display("FAIL rand_cpu_reset cyc=%0d got=%b exp=%b", c, cpu_reset, e_cpu_reset);
      end
      n_checks++;
      if (cpu_resume !== e_cpu_resume) begin
        n_fail++; $display("FAIL rand_cpu_resume cyc=%0d got=%b exp=%b", c, cpu_resume, e_cpu_resume);
      end
      n_checks++;
      if (gpu_start !== e_gpu_start) begin
        n_fail++; $display("FAIL rand_gpu_start cyc=%0d got=%b exp=%b", c, gpu_start, e_gpu_start);
      end
      n_checks++;
      if (mem_we !== e_mem_we) begin
        n_fail++; $display("FAIL rand_mem_we cyc=%0d got=%b exp=%b", c, mem_we, e_mem_we);
      end
      n_checks++;
      if (e_mem_we && (mem_waddr !== e_mem_waddr || mem_wdata !== e_mem_wdata)) begin
        n_fail++; $display("FAIL rand_mem_wr cyc=%0d got a=%0d d=%h exp a=%0d d=%h", c, mem_waddr, mem_wdata, e_mem_waddr, e_mem_wdata);
      end
      n_checks++;
      if (frame_count !== 16'(m_frames)) begin
        n_fail++; $display("FAIL rand_frame_count cyc=%0d got=%0d exp=%0d", c, frame_count, m_frames);
      end
      n_checks++;
      if (overrun_count !== 16'(m_overruns)) begin
        n_fail++; $display("FAIL rand_overrun_count cyc=%0d got=%0d exp=%0d", c, overrun_count, m_overruns);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun_run();
    test_wait_and_vsync();
    test_busy();
    test_reset_midcopy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_frame_sched.md
Name: cpu_frame_sched

Overview:
- Frame-level sequencer for the single-cycle CPU.
- Holds the CPU in reset after power-up, then lets it compute one frame until it executes WAIT.
- On the next vsync it starts the GPU, copies the key-input bitmap into data memory at KEY_MEM by taking the data-memory write port, then pulses resume.
- Sits between the CPU, the data-memory write port, the GPU and the input block.

Parameters:
- DATA_ADDR_WIDTH, 13, data memory address width
- KEY_MEM, 8176, base data address of the key words
- KEY_WORDS, 16, number of key words written per frame (>=1)
- RESET_CYCLES, 4, CPU reset hold length after reset deasserts (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- vsync  in  1  one-cycle frame-start pulse
- keys  in  KEY_WORDS  key bitmap, bit i = key i pressed
- cpu_wait  in  1  CPU wait flag (registered in CPU)
- cpu_reset  out  1  reset to CPU
- cpu_resume  out  1  resume pulse to CPU
- cpu_we  in  1  CPU data write enable
- cpu_waddr  in  DATA_ADDR_WIDTH  CPU write address
- cpu_wdata  in  16  CPU write data
- mem_we  out  1  data memory write enable
- mem_waddr  out  DATA_ADDR_WIDTH  data memory write address
- mem_wdata  out  16  data memory write data
- gpu_start  out  1  one-cycle render start
- gpu_busy  in  1  GPU rendering in progress
- frame_count  out  16  frames completed
- overrun_count  out  16  missed vsyncs

Behaviour:
- Clock is clk; reset is synchronous, active-high, and applies at any time, including mid-frame and mid-copy.
- Reset values:
  - State is BOOT and the hold counter is 0.
  - frame_count and overrun_count are 0.
  - cpu_resume, gpu_start and mem_we are 0.
  - cpu_reset = reset OR (state==BOOT); it is combinationally 1 while reset is high.
- BOOT:
  - The counter increments each cycle.
  - When the counter reaches RESET_CYCLES-1, go to RUN. cpu_reset is therefore 1 for exactly RESET_CYCLES cycles after reset falls.
- Write-port mux:
  - In RUN and DONE, mem_we/mem_waddr/mem_wdata = cpu_we/cpu_waddr/cpu_wdata, combinational, zero latency.
  - In all other states the CPU write is dropped; the CPU is frozen or in reset, so cpu_we is expected 0.
  - In BOOT and RESUME, mem_we=0.
- RUN:
  - If cpu_wait=1 and vsync=1 in the same cycle, the vsync is consumed as in DONE below; no overrun.
  - Else if cpu_wait=1, go to DONE.
  - Else if vsync=1, overrun_count increments; stay in RUN.
- DONE:
  - On vsync with gpu_busy=0: gpu_start=1 for that cycle, latch keys into key_q, idx=0, go to KEYCOPY.
  - On vsync with gpu_busy=1: overrun_count increments; stay in DONE.
- KEYCOPY, one word per cycle:
  - mem_we=1, mem_waddr=(KEY_MEM+idx) truncated to DATA_ADDR_WIDTH, mem_wdata={15'b0, key_q[idx]}.
  - idx increments each cycle; after idx=KEY_WORDS-1, go to RESUME.
  - Lasts exactly KEY_WORDS cycles.
  - The key bitmap written is the value latched at the vsync cycle; later changes to keys are ignored.
- RESUME (one cycle):
  - cpu_resume=1; frame_count increments (wraps 0xFFFF->0); go to RUN.
  - The CPU clears cpu_wait at this edge, so RUN never sees a stale wait.
- A vsync in KEYCOPY or RESUME increments overrun_count, with no other effect.
- overrun_count saturates at 0xFFFF.
- All outputs other than the mux and cpu_reset are registered-state decodes; there is no glitch dependency on vsync except gpu_start, which is a combinational decode of DONE&vsync&!gpu_busy.
- The state machine is one-hot or encoded, implementer's choice. States: BOOT, RUN, DONE, KEYCOPY, RESUME.

Test Plan:
1. Reset for 2 cycles, then release -> cpu_reset high for those 2 cycles plus 4 more; state RUN on cycle 5; counters 0; mem_we follows cpu_we in RUN.
2. cpu_wait=1, then vsync with gpu_busy=0, keys=16'h0005 -> gpu_start pulse at the vsync cycle. The next 16 cycles write addr 8176..8191 with data 1,0,1,0,...0. Then cpu_resume pulses for 1 cycle and frame_count=1.
3. vsync while in RUN (cpu_wait=0) -> overrun_count=1, no gpu_start, no key writes.
4. cpu_wait=1 and vsync on the same cycle -> gpu_start on that cycle, KEYCOPY follows, overrun_count unchanged.
5. DONE with gpu_busy=1 at vsync -> overrun_count increments and state stays DONE. Next vsync with gpu_busy=0 -> normal copy and resume.
6. Assert reset at KEYCOPY idx=7 -> mem_we=0 next cycle, cpu_reset=1, counters 0, and the BOOT hold repeats 4 cycles.
